// File: rtl/uart_loader_pkg.sv
// Shared constants and FSM encoding for the UART frame loader.
package uart_loader_pkg;

  localparam logic [7:0]  START_BYTE     = 8'hAA;
  localparam logic [7:0]  END_BYTE       = 8'h55;
  localparam logic [31:0] ADDR_CPU_RESET = 32'h0000_5000;
  localparam logic [31:0] ADDR_RESUME    = 32'h0000_5001;
  localparam logic [31:0] ADDR_MASTER    = 32'h0000_5002;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } state_t;

endpackage

// File: rtl/uart_loader.sv
// Parses 10-byte UART frames into a memory write or a CPU control-register update,
// with an inter-byte timeout that discards stalled frames.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int WIDTH_D        = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [31:0]        mem_addr,
  output logic [WIDTH_D-1:0] mem_data,
  output logic               mem_we,
  output logic               cpu_reset,
  output logic               cpu_resume,
  output logic               soc_master,
  output logic               frame_error,
  output logic               busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  // Timer value one edge before expiry; reaching it with no byte pending ends the frame.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t             state_r;
  logic [1:0]         cnt_r;
  logic [31:0]        addr_r;
  logic [WIDTH_D-1:0] data_r;
  logic [TW-1:0]      timer_r;

  // Frame FSM, payload assembly, commit decode and timeout, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      addr_r      <= 32'd0;
      data_r      <= '0;
      timer_r     <= '0;
      mem_addr    <= 32'd0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      cpu_reset   <= 1'b0;
      cpu_resume  <= 1'b0;
      soc_master  <= 1'b1;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      frame_error <= 1'b0;
      if (rx_valid) begin
        // A byte always beats a coincident timeout.
        timer_r <= '0;
        case (state_r)
          ST_IDLE: begin
            if (rx_data == START_BYTE) begin
              state_r <= ST_ADDR;
              cnt_r   <= 2'd0;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            addr_r[8*cnt_r +: 8] <= rx_data;
            if (cnt_r == 2'd3) begin
              state_r <= ST_DATA;
              cnt_r   <= 2'd0;
            end else begin
              cnt_r <= cnt_r + 2'd1;
            end
          end
          ST_DATA: begin
            // Bytes beyond the memory width are simply not stored.
            for (int i = 0; i < WIDTH_D / 8; i++) begin
              if (cnt_r == 2'(i)) begin
                data_r[8*i +: 8] <= rx_data;
              end
            end
            if (cnt_r == 2'd3) begin
              state_r <= ST_TAIL;
              cnt_r   <= 2'd0;
            end else begin
              cnt_r <= cnt_r + 2'd1;
            end
          end
          ST_TAIL: begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            busy    <= 1'b0;
            if (rx_data == END_BYTE) begin
              mem_addr <= addr_r;
              mem_data <= data_r;
              case (addr_r)
                ADDR_CPU_RESET: cpu_reset  <= data_r[0];
                ADDR_RESUME:    cpu_resume <= data_r[0];
                ADDR_MASTER:    soc_master <= data_r[0];
                default:        mem_we     <= 1'b1;
              endcase
            end else begin
              frame_error <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            busy    <= 1'b0;
          end
        endcase
      end else if (state_r != ST_IDLE) begin
        if (timer_r == TIMER_LAST) begin
          state_r     <= ST_IDLE;
          cnt_r       <= 2'd0;
          timer_r     <= '0;
          busy        <= 1'b0;
          frame_error <= 1'b1;
        end else begin
          timer_r <= timer_r + 1'b1;
        end
      end else begin
        timer_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed frame table, corner sequences
// and random frames checked against a frame-level reference model.
module tb_uart_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we, cpu_reset, cpu_resume, soc_master, frame_error, busy;

  uart_loader #(.WIDTH_D(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_reset(cpu_reset), .cpu_resume(cpu_resume), .soc_master(soc_master),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] frame;   // byte 0 in the top byte
    logic        we, err, cr, res, ms;
    logic [31:0] addr, data;
  } vec_t;

  vec_t vecs [8];
  int total = 0;
  int bad = 0;

  logic        m_cr, m_res, m_ms;
  logic [31:0] m_addr, m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_cpu_reset"}, cpu_reset, m_cr);
    chk({tag, "_cpu_resume"}, cpu_resume, m_res);
    chk({tag, "_soc_master"}, soc_master, m_ms);
    chk({tag, "_mem_addr"}, mem_addr, m_addr);
    chk({tag, "_mem_data"}, mem_data, m_data);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_data"}, mem_data, 32'h0);
    chk({tag, "_mem_we"}, mem_we, 32'h0);
    chk({tag, "_frame_error"}, frame_error, 32'h0);
    chk({tag, "_busy"}, busy, 32'h0);
    chk({tag, "_cpu_reset"}, cpu_reset, 32'h0);
    chk({tag, "_cpu_resume"}, cpu_resume, 32'h0);
    chk({tag, "_soc_master"}, soc_master, 32'h1);
  endtask

  task automatic send_frame(input logic [79:0] f, input int gap_max, input logic exp_we,
                            input logic exp_err, input logic [31:0] ea, input logic [31:0] ed);
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = f[79-8*i -: 8];
      send_byte(b);
      if (i < 9) begin
        chk("mid_busy", busy, 32'h1);
        chk("mid_we", mem_we, 32'h0);
        chk("mid_err", frame_error, 32'h0);
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(posedge clk);
      end
    end
    chk("end_we", mem_we, exp_we);
    chk("end_err", frame_error, exp_err);
    chk("end_busy", busy, 32'h0);
    if (exp_we) begin
      chk("end_addr", mem_addr, ea);
      chk("end_data", mem_data, ed);
    end
    @(posedge clk);
    #1;
    chk("pulse_we", mem_we, 32'h0);
    chk("pulse_err", frame_error, 32'h0);
  endtask

  function automatic logic [79:0] build(input logic [31:0] a, input logic [31:0] d,
                                        input logic [7:0] tail);
    return {8'hAA, a[7:0], a[15:8], a[23:16], a[31:24], d[7:0], d[15:8], d[23:16], d[31:24], tail};
  endfunction

  // Reference model: outcome of a whole frame from its fields.
  task automatic model_frame(input logic [31:0] a, input logic [31:0] d, input logic good,
                             output logic exp_we);
    exp_we = 1'b0;
    if (good) begin
      m_addr = a;
      m_data = d;
      if (a == 32'h5000)      m_cr  = d[0];
      else if (a == 32'h5001) m_res = d[0];
      else if (a == 32'h5002) m_ms  = d[0];
      else                    exp_we = 1'b1;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  t, g;
    logic        good, ew;
    int          k;

    vecs[0] = '{frame: 80'hAA_00_40_00_00_03_00_01_00_55, we: 1, err: 0, cr: 0, res: 0, ms: 1, addr: 32'h0000_4000, data: 32'h0001_0003};
    vecs[1] = '{frame: 80'hAA_00_50_00_00_01_00_00_00_55, we: 0, err: 0, cr: 1, res: 0, ms: 1, addr: 32'h0000_5000, data: 32'h0000_0001};
    vecs[2] = '{frame: 80'hAA_02_50_00_00_00_00_00_00_55, we: 0, err: 0, cr: 1, res: 0, ms: 0, addr: 32'h0000_5002, data: 32'h0000_0000};
    vecs[3] = '{frame: 80'hAA_10_20_30_40_AA_BB_CC_DD_54, we: 0, err: 1, cr: 1, res: 0, ms: 0, addr: 32'h0000_5002, data: 32'h0000_0000};
    vecs[4] = '{frame: 80'hAA_10_20_30_40_AA_BB_CC_DD_55, we: 1, err: 0, cr: 1, res: 0, ms: 0, addr: 32'h4030_2010, data: 32'hDDCC_BBAA};
    vecs[5] = '{frame: 80'hAA_01_50_00_00_FF_FF_FF_FF_55, we: 0, err: 0, cr: 1, res: 1, ms: 0, addr: 32'h0000_5001, data: 32'hFFFF_FFFF};
    vecs[6] = '{frame: 80'hAA_00_50_00_00_FE_00_00_00_55, we: 0, err: 0, cr: 0, res: 1, ms: 0, addr: 32'h0000_5000, data: 32'h0000_00FE};
    vecs[7] = '{frame: 80'hAA_00_50_00_01_01_00_00_00_55, we: 1, err: 0, cr: 0, res: 1, ms: 0, addr: 32'h0100_5000, data: 32'h0000_0001};

    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("rst_rel");

    // Garbage in IDLE is ignored silently.
    send_byte(8'h12);
    chk("garb1_err", frame_error, 32'h0);
    chk("garb1_busy", busy, 32'h0);
    send_byte(8'h55);
    chk("garb2_err", frame_error, 32'h0);
    chk("garb2_busy", busy, 32'h0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].frame, 0, vecs[i].we, vecs[i].err, vecs[i].addr, vecs[i].data);
      m_cr = vecs[i].cr; m_res = vecs[i].res; m_ms = vecs[i].ms;
      m_addr = vecs[i].addr; m_data = vecs[i].data;
      check_regs($sformatf("vec%0d", i));
    end

    // Timeout after the 5th byte.
    send_byte(8'hAA);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    chk("to_start_err", frame_error, 32'h0);
    k = 0;
    while (k < 3 * TO && frame_error !== 1'b1) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("to_cycles", k, TO);
    chk("to_busy", busy, 32'h0);
    chk("to_we", mem_we, 32'h0);
    @(posedge clk);
    #1;
    chk("to_pulse", frame_error, 32'h0);
    check_regs("to");

    // A byte arriving on the expiry edge keeps the frame alive.
    a = 32'h0000_1234;
    d = 32'h1234_5678;
    send_byte(8'hAA);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    repeat (TO - 1) @(posedge clk);
    send_byte(d[7:0]);
    chk("race_err", frame_error, 32'h0);
    chk("race_busy", busy, 32'h1);
    for (int i = 1; i < 4; i++) send_byte(d[8*i +: 8]);
    send_byte(8'h55);
    model_frame(a, d, 1'b1, ew);
    chk("race_we", mem_we, ew);
    chk("race_err2", frame_error, 32'h0);
    check_regs("race");

    // Random frames against the model.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(5, 0))
        0: a = 32'h5000;
        1: a = 32'h5001;
        2: a = 32'h5002;
        default: a = $urandom;
      endcase
      d = $urandom;
      if ($urandom_range(3, 0) == 0) d[7:0] = 8'hAA;
      good = ($urandom_range(4, 0) != 0);
      t = $urandom;
      if (good) t = 8'h55;
      else if (t == 8'h55) t = 8'h56;
      repeat ($urandom_range(2, 0)) begin
        g = $urandom;
        if (g == 8'hAA) g = 8'h00;
        send_byte(g);
        chk("rnd_garb_err", frame_error, 32'h0);
        chk("rnd_garb_busy", busy, 32'h0);
      end
      model_frame(a, d, good, ew);
      send_frame(build(a, d, t), 3, ew, !good, a, d);
      check_regs("rnd");
    end

    // Reset after the 7th byte aborts silently.
    a = 32'h0000_0100;
    d = 32'hCAFE_F00D;
    for (int i = 0; i < 7; i++) send_byte(build(a, d, 8'h55)[79-8*i -: 8]);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("post_rst");
    m_cr = 1'b0; m_res = 1'b0; m_ms = 1'b1; m_addr = 32'h0; m_data = 32'h0;
    model_frame(a, d, 1'b1, ew);
    send_frame(build(a, d, 8'h55), 0, ew, 1'b0, a, d);
    check_regs("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
